// File: rtl/region_guard_pkg.sv
// Shared types and constants for the region_guard data-access guard.
// Mode bit positions index each region's 3-bit mode field.
package region_guard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_KILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_e;

    localparam int MODE_RD_PROT  = 0;
    localparam int MODE_WR_PROT  = 1;
    localparam int MODE_TRUST_WR = 2;

    localparam logic [1:0] VT_NONE       = 2'b00;
    localparam logic [1:0] VT_UNTRUSTED  = 2'b01;
    localparam logic [1:0] VT_TRUSTED_WR = 2'b10;

    localparam int HOLD_W = 8;

endpackage

// File: rtl/region_match.sv
// Address-range comparator for one protected region.
// Bounds are widened to 17 bits so regions ending at 0xFFFF never wrap.
module region_match (
    input  logic [15:0] base,
    input  logic [15:0] size,
    input  logic [15:0] data_addr,
    output logic        hit
);

    logic [16:0] addr_s;
    logic [16:0] lo_s;
    logic [16:0] end_s;

    assign addr_s = {1'b0, data_addr};
    assign lo_s   = {1'b0, base};
    assign end_s  = {1'b0, base} + {1'b0, size};

    // addr+1 <= base+size is the wrap-free form of addr <= base+size-1
    assign hit = (size != 16'd0) && (addr_s >= lo_s) && ((addr_s + 17'd1) <= end_s);

endmodule

// File: rtl/region_guard.sv
// Data-region access guard: flags untrusted access to protected regions and
// trusted writes outside trusted-write regions, forces a held reset, logs the cause.
module region_guard
    import region_guard_pkg::*;
#(
    parameter int                  NREG          = 4,
    parameter logic [NREG*16-1:0]  REG_BASE      = {16'hFEFE, 16'h9000, 16'h8000, 16'h0400},
    parameter logic [NREG*16-1:0]  REG_SIZE      = {16'h0040, 16'h001F, 16'h0020, 16'h0C00},
    parameter logic [NREG*3-1:0]   REG_MODE      = {3'b011, 3'b110, 3'b100, 3'b111},
    parameter logic [15:0]         SMEM_BASE     = 16'hA000,
    parameter logic [15:0]         SMEM_SIZE     = 16'h4000,
    parameter logic [15:0]         RESET_HANDLER = 16'hFFFE,
    parameter int                  HOLD_CYCLES   = 4,
    parameter int                  CNT_W         = 8
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [15:0]                              pc,
    input  logic [15:0]                              data_addr,
    input  logic                                     r_en,
    input  logic                                     w_en,
    input  logic                                     log_clr,
    output logic                                     reset,
    output logic                                     viol_valid,
    output logic [1:0]                               viol_type,
    output logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] viol_region,
    output logic [CNT_W-1:0]                         viol_cnt
);

    localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [16:0] SMEM_END = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};

    logic [NREG-1:0]   hit_s;
    logic [NREG-1:0]   v1_hit_s;
    logic [NREG-1:0]   trust_hit_s;
    logic              pc_trusted_s;
    logic              v1_s;
    logic              v2_s;
    logic              viol_s;
    logic [1:0]        cause_type_s;
    logic [RW-1:0]     cause_region_s;
    logic [CNT_W-1:0]  cnt_inc_s;

    state_e            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              reset_q;
    logic              viol_valid_q;
    logic [1:0]        viol_type_q;
    logic [RW-1:0]     viol_region_q;
    logic [CNT_W-1:0]  viol_cnt_q;

    genvar g;
    generate
        for (g = 0; g < NREG; g++) begin : g_region
            region_match u_match (
                .base      (REG_BASE[g*16 +: 16]),
                .size      (REG_SIZE[g*16 +: 16]),
                .data_addr (data_addr),
                .hit       (hit_s[g])
            );
            assign v1_hit_s[g]    = hit_s[g] & ((r_en & REG_MODE[g*3 + MODE_RD_PROT]) |
                                                (w_en & REG_MODE[g*3 + MODE_WR_PROT]));
            assign trust_hit_s[g] = hit_s[g] & REG_MODE[g*3 + MODE_TRUST_WR];
        end
    endgenerate

    // The last trusted pc is base+size-2, written as pc+2 <= base+size to avoid wrap
    assign pc_trusted_s = ({1'b0, pc} >= {1'b0, SMEM_BASE}) && (({1'b0, pc} + 17'd2) <= SMEM_END);
    assign v1_s         = !pc_trusted_s && (|v1_hit_s);
    assign v2_s         = pc_trusted_s && w_en && !(|trust_hit_s);
    assign viol_s       = v1_s || v2_s;
    assign cnt_inc_s    = (viol_cnt_q == {CNT_W{1'b1}}) ? viol_cnt_q : (viol_cnt_q + CNT_W'(1));

    // Cause priority: untrusted access first, lowest offending region index wins
    always_comb begin
        cause_type_s   = VT_NONE;
        cause_region_s = '0;
        if (v1_s) begin
            cause_type_s = VT_UNTRUSTED;
            for (int i = NREG - 1; i >= 0; i--) begin
                cause_region_s = v1_hit_s[i] ? RW'(i) : cause_region_s;
            end
        end else if (v2_s) begin
            cause_type_s = VT_TRUSTED_WR;
        end else begin
            cause_type_s = VT_NONE;
        end
    end

    // Kill/hold/release FSM together with the sticky violation log
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            hold_q        <= '0;
            reset_q       <= 1'b0;
            viol_valid_q  <= 1'b0;
            viol_type_q   <= VT_NONE;
            viol_region_q <= '0;
            viol_cnt_q    <= '0;
        end else begin
            if (viol_s) begin
                viol_cnt_q <= (state_q == ST_RUN && log_clr) ? CNT_W'(1) : cnt_inc_s;
            end else if (state_q == ST_RUN && log_clr) begin
                viol_cnt_q <= '0;
            end

            case (state_q)
                ST_RUN: begin
                    if (viol_s) begin
                        state_q       <= ST_KILL;
                        hold_q        <= HOLD_LOAD;
                        reset_q       <= 1'b1;
                        viol_valid_q  <= 1'b1;
                        viol_type_q   <= cause_type_s;
                        viol_region_q <= cause_region_s;
                    end else if (log_clr) begin
                        viol_valid_q  <= 1'b0;
                        viol_type_q   <= VT_NONE;
                        viol_region_q <= '0;
                    end
                end
                ST_KILL: begin
                    if (viol_s) begin
                        hold_q <= HOLD_LOAD;
                    end else if (hold_q == '0) begin
                        state_q <= ST_ARMED;
                    end else begin
                        hold_q <= hold_q - HOLD_W'(1);
                    end
                end
                ST_ARMED: begin
                    if (viol_s) begin
                        state_q <= ST_KILL;
                        hold_q  <= HOLD_LOAD;
                    end else if (pc == RESET_HANDLER) begin
                        state_q <= ST_RUN;
                        reset_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                    hold_q  <= '0;
                    reset_q <= 1'b0;
                end
            endcase
        end
    end

    assign reset       = reset_q;
    assign viol_valid  = viol_valid_q;
    assign viol_type   = viol_type_q;
    assign viol_region = viol_region_q;
    assign viol_cnt    = viol_cnt_q;

endmodule

// File: tb/tb_region_guard.sv
// Directed self-checking bench for region_guard with default parameters.
module tb_region_guard;

    logic        clk;
    logic        rst;
    logic [15:0] pc;
    logic [15:0] data_addr;
    logic        r_en;
    logic        w_en;
    logic        log_clr;
    logic        reset;
    logic        viol_valid;
    logic [1:0]  viol_type;
    logic [1:0]  viol_region;
    logic [7:0]  viol_cnt;

    int checks;
    int failures;
    int n;

    region_guard dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .data_addr   (data_addr),
        .r_en        (r_en),
        .w_en        (w_en),
        .log_clr     (log_clr),
        .reset       (reset),
        .viol_valid  (viol_valid),
        .viol_type   (viol_type),
        .viol_region (viol_region),
        .viol_cnt    (viol_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] p, input logic [15:0] a, input logic r, input logic w);
        pc = p; data_addr = a; r_en = r; w_en = w;
    endtask

    task automatic check_log(input string tag, input logic v, input logic [1:0] t,
                             input logic [1:0] rg, input logic [7:0] c);
        check({tag, ".valid"}, 32'(viol_valid), 32'(v));
        check({tag, ".type"}, 32'(viol_type), 32'(t));
        check({tag, ".region"}, 32'(viol_region), 32'(rg));
        check({tag, ".cnt"}, 32'(viol_cnt), 32'(c));
    endtask

    // Counts reset-high cycles (one already observed) with pc at the handler.
    task automatic count_reset(output int cnt);
        drive(16'hFFFE, 16'h0000, 1'b0, 1'b0);
        cnt = 1;
        while (reset === 1'b1 && cnt < 30) begin
            tick();
            if (reset === 1'b1) cnt++;
        end
    endtask

    task automatic release_and_clear(input string tag);
        int k;
        drive(16'hFFFE, 16'h0000, 1'b0, 1'b0);
        k = 0;
        while (reset === 1'b1 && k < 30) begin
            tick();
            k++;
        end
        check({tag, ".released"}, 32'(reset), 32'd0);
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        pc = 16'h0000;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        log_clr = 1'b0;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        check("rst.reset", 32'(reset), 32'd0);
        check_log("rst", 1'b0, 2'b00, 2'd0, 8'd0);
        rst = 1'b0;
        tick();

        // untrusted read of region 0, then minimum 5-cycle pulse with handler pc
        drive(16'h4000, 16'h0400, 1'b1, 1'b0);
        tick();
        check("rd0.reset", 32'(reset), 32'd1);
        check_log("rd0", 1'b1, 2'b01, 2'd0, 8'd1);
        count_reset(n);
        check("rd0.pulse_len", 32'(n), 32'd5);
        check_log("rd0.after", 1'b1, 2'b01, 2'd0, 8'd1);
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        check_log("clr1", 1'b0, 2'b00, 2'd0, 8'd0);

        // trusted writes: allowed into TRUST_WR regions, flagged elsewhere
        drive(16'hA010, 16'h8010, 1'b0, 1'b1);
        tick();
        check("tw8010.reset", 32'(reset), 32'd0);
        drive(16'hA010, 16'h901E, 1'b0, 1'b1);
        tick();
        check("tw901E.reset", 32'(reset), 32'd0);
        check("tw901E.cnt", 32'(viol_cnt), 32'd0);
        drive(16'hA010, 16'h2000, 1'b0, 1'b1);
        tick();
        check("tw2000.reset", 32'(reset), 32'd1);
        check_log("tw2000", 1'b1, 2'b10, 2'd0, 8'd1);
        release_and_clear("tw2000");
        drive(16'hA010, 16'h901F, 1'b0, 1'b1);
        tick();
        check_log("tw901F", 1'b1, 2'b10, 2'd0, 8'd1);
        release_and_clear("tw901F");
        drive(16'hDFFE, 16'h2000, 1'b0, 1'b1);
        tick();
        check_log("twDFFE", 1'b1, 2'b10, 2'd0, 8'd1);
        release_and_clear("twDFFE");

        // untrusted accesses to region 2 and region 3
        drive(16'h4000, 16'h9000, 1'b0, 1'b1);
        tick();
        check_log("uw9000", 1'b1, 2'b01, 2'd2, 8'd1);
        release_and_clear("uw9000");
        drive(16'h4000, 16'h9000, 1'b1, 1'b0);
        tick();
        check("ur9000.reset", 32'(reset), 32'd0);
        check("ur9000.cnt", 32'(viol_cnt), 32'd0);
        drive(16'hDFFF, 16'h0400, 1'b1, 1'b0);
        tick();
        check_log("urDFFF", 1'b1, 2'b01, 2'd0, 8'd1);
        release_and_clear("urDFFF");
        drive(16'h4000, 16'hFF3D, 1'b1, 1'b0);
        tick();
        check_log("urFF3D", 1'b1, 2'b01, 2'd3, 8'd1);
        release_and_clear("urFF3D");
        drive(16'h4000, 16'hFF3E, 1'b1, 1'b0);
        tick();
        check("urFF3E.reset", 32'(reset), 32'd0);

        // violation during ARMED restarts the full hold
        drive(16'h4000, 16'h0400, 1'b1, 1'b0);
        tick();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        check("armed.reset", 32'(reset), 32'd1);
        drive(16'h4000, 16'h0400, 1'b1, 1'b0);
        tick();
        check("rearm.cnt", 32'(viol_cnt), 32'd2);
        count_reset(n);
        check("rearm.pulse_len", 32'(n), 32'd5);
        release_and_clear("rearm");

        // long violation burst saturates the counter; log_clr ignored while killed
        drive(16'h4000, 16'h9000, 1'b0, 1'b1);
        for (int i = 0; i < 300; i++) tick();
        check("sat.reset", 32'(reset), 32'd1);
        check_log("sat", 1'b1, 2'b01, 2'd2, 8'd255);
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        log_clr = 1'b1;
        tick();
        log_clr = 1'b0;
        check_log("kill_clr", 1'b1, 2'b01, 2'd2, 8'd255);
        drive(16'hFFFE, 16'h0000, 1'b0, 1'b0);
        n = 0;
        while (reset === 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check("sat.released", 32'(reset), 32'd0);

        // log_clr together with a fresh violation in RUN
        log_clr = 1'b1;
        drive(16'h4000, 16'h0400, 1'b1, 1'b0);
        tick();
        log_clr = 1'b0;
        check_log("clr_viol", 1'b1, 2'b01, 2'd0, 8'd1);
        release_and_clear("clr_viol");
        check_log("clr_all", 1'b0, 2'b00, 2'd0, 8'd0);

        // asynchronous reset in the middle of the hold
        drive(16'h4000, 16'h0400, 1'b1, 1'b0);
        tick();
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        check("midhold.reset", 32'(reset), 32'd1);
        rst = 1'b1;
        #1;
        check("async.reset", 32'(reset), 32'd0);
        check_log("async", 1'b0, 2'b00, 2'd0, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("postrst.reset", 32'(reset), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
